ct_fcnvt_stoh_rnd: RTL and testbench

//  Round-and-pack stage of the single->half FP convert path. Sits directly downstream of the

---
 rtl/ct_fcnvt_pkg.sv | 47 ++++
 rtl/ct_fcnvt_rnd_inc.sv | 28 ++
 rtl/ct_fcnvt_stoh_rnd.sv | 138 +++++++++++++
 tb/tb_ct_fcnvt_stoh_rnd.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ct_fcnvt_pkg.sv
// Shared encodings and constants for the FP convert round/pack stages.
// Also holds the S1 payload layout and the overflow-result selection.
package ct_fcnvt_pkg;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  localparam logic [15:0] HALF_QNAN = 16'h7E00;
  localparam logic [14:0] HALF_MAXF = 15'h7BFF;
  localparam logic [14:0] HALF_INF  = 15'h7C00;

  localparam int FFLAG_NV = 4;
  localparam int FFLAG_DZ = 3;
  localparam int FFLAG_OF = 2;
  localparam int FFLAG_UF = 1;
  localparam int FFLAG_NX = 0;

  typedef struct packed {
    logic [2:0] rm;
    logic       sign;
    logic [4:0] expt;
    logic [9:0] man;
    logic       ovf;
    logic       is_nan;
    logic       is_snan;
    logic       is_inf;
    logic       is_zero;
    logic       inc;
    logic       nx;
  } stoh_s1_t;

  // Overflow goes to infinity only when the rounding direction points away from zero.
  function automatic logic [15:0] ovf_result(input logic [2:0] rm, input logic sign);
    logic to_inf;
    case (rm)
      RM_RTZ:  to_inf = 1'b0;
      RM_RDN:  to_inf = sign;
      RM_RUP:  to_inf = ~sign;
      default: to_inf = 1'b1;
    endcase
    ovf_result = to_inf ? {sign, HALF_INF} : {sign, HALF_MAXF};
  endfunction

endpackage

// File: rtl/ct_fcnvt_rnd_inc.sv
// Rounding-increment decision for narrowing converters: (rm, sign, guard, sticky, lsb) -> inc, nx.
// Unknown rounding modes fall back to round-to-nearest-even.
module ct_fcnvt_rnd_inc
  import ct_fcnvt_pkg::*;
(
  input  logic [2:0] rm,
  input  logic       sign,
  input  logic       g,
  input  logic       s,
  input  logic       lsb,
  output logic       inc,
  output logic       nx
);

  always_comb begin
    inc = 1'b0;
    case (rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & (g | s);
      RM_RUP:  inc = ~sign & (g | s);
      RM_RMM:  inc = g;
      default: inc = g & (s | lsb);
    endcase
  end

  assign nx = g | s;

endmodule

// File: rtl/ct_fcnvt_stoh_rnd.sv
// Round-and-pack stage of the single->half convert: two-register elastic pipeline
// (S1 input/increment register, S2 packed result register) with valid/ready flow control.
module ct_fcnvt_stoh_rnd
  import ct_fcnvt_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int X_W   = 25
) (
  input  logic               forever_cpuclk,
  input  logic               cpurst,
  input  logic               stoh_rnd_flush,
  input  logic               stoh_rnd_in_vld,
  output logic               stoh_rnd_in_rdy,
  input  logic [2:0]         stoh_rnd_rm,
  input  logic               stoh_rnd_sign,
  input  logic [EXP_W-1:0]   stoh_rnd_expt,
  input  logic [MAN_W:0]     stoh_rnd_f_v,
  input  logic [X_W-1:0]     stoh_rnd_f_x,
  input  logic               stoh_rnd_ovf,
  input  logic               stoh_rnd_is_nan,
  input  logic               stoh_rnd_is_snan,
  input  logic               stoh_rnd_is_inf,
  input  logic               stoh_rnd_is_zero,
  output logic               stoh_rnd_out_vld,
  input  logic               stoh_rnd_out_rdy,
  output logic [15:0]        stoh_rnd_result,
  output logic [4:0]         stoh_rnd_fflags
);

  logic        s1_vld;
  logic        s2_vld;
  stoh_s1_t    s1_q;
  stoh_s1_t    s1_d;
  logic [15:0] res_q;
  logic [4:0]  flags_q;
  logic [15:0] res_d;
  logic [4:0]  flags_d;

  logic        s1_adv;
  logic        s2_adv;
  logic        accept;
  logic        rnd_inc;
  logic        rnd_nx;
  logic [14:0] sum;
  logic        sum_of;
  logic        unused_hidden;

  // The hidden bit is implied by the exponent field; only stored bits are packed.
  assign unused_hidden = stoh_rnd_f_v[MAN_W];

  // Handshake: a stage moves forward when its successor is empty or draining this edge.
  // S2 drains on out_rdy; S1 advances into S2 when S2 can move; input is taken when S1
  // is empty or advancing. A flush drops everything in flight, including this cycle's input.
  assign s2_adv          = ~s2_vld | stoh_rnd_out_rdy;
  assign s1_adv          = s1_vld & s2_adv;
  assign stoh_rnd_in_rdy = ~s1_vld | s1_adv;
  assign accept          = stoh_rnd_in_vld & stoh_rnd_in_rdy & ~stoh_rnd_flush;

  ct_fcnvt_rnd_inc u_rnd_inc (
    .rm   (stoh_rnd_rm),
    .sign (stoh_rnd_sign),
    .g    (stoh_rnd_f_x[X_W-1]),
    .s    (|stoh_rnd_f_x[X_W-2:0]),
    .lsb  (stoh_rnd_f_v[0]),
    .inc  (rnd_inc),
    .nx   (rnd_nx)
  );

  always_comb begin
    s1_d         = '0;
    s1_d.rm      = stoh_rnd_rm;
    s1_d.sign    = stoh_rnd_sign;
    s1_d.expt    = stoh_rnd_expt;
    s1_d.man     = stoh_rnd_f_v[MAN_W-1:0];
    s1_d.ovf     = stoh_rnd_ovf;
    s1_d.is_nan  = stoh_rnd_is_nan;
    s1_d.is_snan = stoh_rnd_is_snan;
    s1_d.is_inf  = stoh_rnd_is_inf;
    s1_d.is_zero = stoh_rnd_is_zero;
    s1_d.inc     = rnd_inc;
    s1_d.nx      = rnd_nx;
  end

  // Mantissa carry ripples straight into the exponent, covering denorm->normal and binade steps.
  assign sum    = {s1_q.expt, s1_q.man} + 15'(s1_q.inc);
  assign sum_of = s1_q.ovf | (sum[14:10] == 5'h1F);

  always_comb begin
    res_d   = {s1_q.sign, sum};
    flags_d = '0;
    if (s1_q.is_nan | s1_q.is_snan) begin
      res_d             = HALF_QNAN;
      flags_d[FFLAG_NV] = s1_q.is_snan;
    end else if (s1_q.is_inf) begin
      res_d = {s1_q.sign, HALF_INF};
    end else if (s1_q.is_zero) begin
      res_d = {s1_q.sign, 15'h0000};
    end else if (sum_of) begin
      res_d             = ovf_result(s1_q.rm, s1_q.sign);
      flags_d[FFLAG_OF] = 1'b1;
      flags_d[FFLAG_NX] = 1'b1;
    end else begin
      // Tininess is judged after rounding.
      flags_d[FFLAG_NX] = s1_q.nx;
      flags_d[FFLAG_UF] = s1_q.nx & (sum[14:10] == 5'h00);
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      s1_vld  <= 1'b0;
      s2_vld  <= 1'b0;
      s1_q    <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      if (stoh_rnd_flush)  s1_vld <= 1'b0;
      else if (accept)     s1_vld <= 1'b1;
      else if (s1_adv)     s1_vld <= 1'b0;

      if (stoh_rnd_flush)        s2_vld <= 1'b0;
      else if (s1_adv)           s2_vld <= 1'b1;
      else if (stoh_rnd_out_rdy) s2_vld <= 1'b0;

      if (accept) s1_q <= s1_d;
      if (s1_adv) begin
        res_q   <= res_d;
        flags_q <= flags_d;
      end
    end
  end

  assign stoh_rnd_out_vld = s2_vld;
  assign stoh_rnd_result  = res_q;
  assign stoh_rnd_fflags  = flags_q;

endmodule

// File: tb/tb_ct_fcnvt_stoh_rnd.sv
// Directed-vector bench for the single->half round-and-pack stage.
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.
module tb_ct_fcnvt_stoh_rnd;

  typedef struct packed {
    logic [2:0]  rm;
    logic        sign;
    logic [4:0]  expt;
    logic [10:0] f_v;
    logic [24:0] f_x;
    logic        ovf;
    logic        nan;
    logic        snan;
    logic        inf;
    logic        zero;
  } op_t;

  logic        clk = 1'b0;
  logic        cpurst;
  logic        flush;
  logic        in_vld;
  logic        in_rdy;
  logic [2:0]  rm;
  logic        sign;
  logic [4:0]  expt;
  logic [10:0] f_v;
  logic [24:0] f_x;
  logic        ovf;
  logic        is_nan;
  logic        is_snan;
  logic        is_inf;
  logic        is_zero;
  logic        out_vld;
  logic        out_rdy;
  logic [15:0] result;
  logic [4:0]  fflags;

  int total = 0;
  int bad   = 0;
  logic [20:0] exp_q[$];

  always #5 clk = ~clk;

  ct_fcnvt_stoh_rnd dut (
    .forever_cpuclk   (clk),
    .cpurst           (cpurst),
    .stoh_rnd_flush   (flush),
    .stoh_rnd_in_vld  (in_vld),
    .stoh_rnd_in_rdy  (in_rdy),
    .stoh_rnd_rm      (rm),
    .stoh_rnd_sign    (sign),
    .stoh_rnd_expt    (expt),
    .stoh_rnd_f_v     (f_v),
    .stoh_rnd_f_x     (f_x),
    .stoh_rnd_ovf     (ovf),
    .stoh_rnd_is_nan  (is_nan),
    .stoh_rnd_is_snan (is_snan),
    .stoh_rnd_is_inf  (is_inf),
    .stoh_rnd_is_zero (is_zero),
    .stoh_rnd_out_vld (out_vld),
    .stoh_rnd_out_rdy (out_rdy),
    .stoh_rnd_result  (result),
    .stoh_rnd_fflags  (fflags)
  );

  function automatic op_t mk(input logic [2:0] m, input logic sg, input logic [4:0] e,
                             input logic [10:0] fv, input logic [24:0] fx);
    mk      = '0;
    mk.rm   = m;
    mk.sign = sg;
    mk.expt = e;
    mk.f_v  = fv;
    mk.f_x  = fx;
  endfunction

  task automatic set_in(input op_t o);
    rm = o.rm; sign = o.sign; expt = o.expt; f_v = o.f_v; f_x = o.f_x;
    ovf = o.ovf; is_nan = o.nan; is_snan = o.snan; is_inf = o.inf; is_zero = o.zero;
  endtask

  // Present an op and hold it until the stage takes it; returns at the falling edge after acceptance.
  task automatic put_op(input op_t o, output bit ok);
    int n;
    set_in(o);
    in_vld = 1'b1;
    n = 0;
    while (!in_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = in_rdy;
    @(negedge clk);
    in_vld = 1'b0;
  endtask

  // Wait (bounded) for a result with out_rdy high; lat is falling edges waited, -1 on timeout.
  task automatic get_out(output logic [15:0] r, output logic [4:0] f, output int lat);
    int n;
    n = 0;
    while (!out_vld && n < 50) begin
      @(negedge clk);
      n++;
    end
    lat = out_vld ? n : -1;
    r   = result;
    f   = fflags;
    @(negedge clk);
  endtask

  task automatic do_reset();
    cpurst = 1'b1; flush = 1'b0; in_vld = 1'b0; out_rdy = 1'b1;
    set_in('0);
    repeat (3) @(negedge clk);
    cpurst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (out_vld !== 1'b0) begin bad++; $display("FAIL reset_out_vld got=%b want=0", out_vld); end
    total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL reset_in_rdy got=%b want=1", in_rdy); end
    total++; if (result !== 16'h0000) begin bad++; $display("FAIL reset_result got=%h want=0000", result); end
    total++; if (fflags !== 5'h00) begin bad++; $display("FAIL reset_fflags got=%h want=00", fflags); end
  endtask

  task automatic test_latency();
    op_t o; bit ok; logic [15:0] r; logic [4:0] f; int lat;
    o = mk(3'd0, 1'b0, 5'd15, 11'h400, 25'h0);
    put_op(o, ok);
    total++; if (out_vld !== 1'b0) begin bad++; $display("FAIL latency_early got=%b want=0", out_vld); end
    get_out(r, f, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL latency_cycles got=%0d want=1", lat); end
    total++; if (r !== 16'h3C00 || f !== 5'h00) begin
      bad++; $display("FAIL latency_exact got=%h/%h want=3c00/00", r, f);
    end
  endtask

  task automatic test_rounding();
    op_t v[10]; logic [15:0] er[10]; logic [4:0] ef[10];
    bit ok; logic [15:0] r; logic [4:0] f; int lat;
    v[0] = mk(3'd0, 1'b0, 5'd15, 11'h400, 25'h1000000); er[0] = 16'h3C00; ef[0] = 5'h01;
    v[1] = mk(3'd0, 1'b0, 5'd15, 11'h7FF, 25'h1000000); er[1] = 16'h4000; ef[1] = 5'h01;
    v[2] = mk(3'd3, 1'b0, 5'd0,  11'h3FF, 25'h1800000); er[2] = 16'h0400; ef[2] = 5'h01;
    v[3] = mk(3'd0, 1'b0, 5'd0,  11'h001, 25'h0000001); er[3] = 16'h0001; ef[3] = 5'h03;
    v[4] = mk(3'd4, 1'b0, 5'd15, 11'h400, 25'h1000000); er[4] = 16'h3C01; ef[4] = 5'h01;
    v[5] = mk(3'd2, 1'b1, 5'd15, 11'h400, 25'h0000001); er[5] = 16'hBC01; ef[5] = 5'h01;
    v[6] = mk(3'd3, 1'b1, 5'd15, 11'h400, 25'h0000001); er[6] = 16'hBC00; ef[6] = 5'h01;
    v[7] = mk(3'd7, 1'b0, 5'd15, 11'h401, 25'h1000000); er[7] = 16'h3C02; ef[7] = 5'h01;
    v[8] = mk(3'd0, 1'b0, 5'd0,  11'h200, 25'h0000000); er[8] = 16'h0200; ef[8] = 5'h00;
    v[9] = mk(3'd1, 1'b0, 5'd15, 11'h7FF, 25'h1FFFFFF); er[9] = 16'h3FFF; ef[9] = 5'h01;
    for (int i = 0; i < 10; i++) begin
      put_op(v[i], ok);
      get_out(r, f, lat);
      total++; if (!ok || lat < 0 || r !== er[i]) begin
        bad++; $display("FAIL round_result[%0d] got=%h want=%h", i, r, er[i]);
      end
      total++; if (f !== ef[i]) begin
        bad++; $display("FAIL round_fflags[%0d] got=%h want=%h", i, f, ef[i]);
      end
    end
  endtask

  task automatic test_overflow();
    op_t v[5]; logic [15:0] er[5];
    bit ok; logic [15:0] r; logic [4:0] f; int lat;
    v[0] = mk(3'd1, 1'b1, 5'd30, 11'h7FF, 25'h1FFFFFF); v[0].ovf = 1'b1; er[0] = 16'hFBFF;
    v[1] = mk(3'd0, 1'b1, 5'd30, 11'h7FF, 25'h1FFFFFF);                  er[1] = 16'hFC00;
    v[2] = mk(3'd0, 1'b1, 5'd30, 11'h7FF, 25'h1FFFFFF); v[2].ovf = 1'b1; er[2] = 16'hFC00;
    v[3] = mk(3'd3, 1'b0, 5'd30, 11'h7FF, 25'h0000001);                  er[3] = 16'h7C00;
    v[4] = mk(3'd2, 1'b0, 5'd30, 11'h7FF, 25'h0000001); v[4].ovf = 1'b1; er[4] = 16'h7BFF;
    for (int i = 0; i < 5; i++) begin
      put_op(v[i], ok);
      get_out(r, f, lat);
      total++; if (!ok || lat < 0 || r !== er[i]) begin
        bad++; $display("FAIL ovf_result[%0d] got=%h want=%h", i, r, er[i]);
      end
      total++; if (f !== 5'h05) begin
        bad++; $display("FAIL ovf_fflags[%0d] got=%h want=05", i, f);
      end
    end
  endtask

  task automatic test_specials();
    op_t v[4]; logic [15:0] er[4]; logic [4:0] ef[4];
    bit ok; logic [15:0] r; logic [4:0] f; int lat;
    for (int i = 0; i < 4; i++) begin
      v[i] = mk(3'd0, 1'b1, 5'd30, 11'h7FF, 25'h1FFFFFF);
      v[i].ovf = 1'b1;
    end
    v[0].snan = 1'b1; er[0] = 16'h7E00; ef[0] = 5'h10;
    v[1].nan  = 1'b1; er[1] = 16'h7E00; ef[1] = 5'h00;
    v[2].inf  = 1'b1; er[2] = 16'hFC00; ef[2] = 5'h00;
    v[3].zero = 1'b1; er[3] = 16'h8000; ef[3] = 5'h00;
    for (int i = 0; i < 4; i++) begin
      put_op(v[i], ok);
      get_out(r, f, lat);
      total++; if (!ok || lat < 0 || r !== er[i]) begin
        bad++; $display("FAIL special_result[%0d] got=%h want=%h", i, r, er[i]);
      end
      total++; if (f !== ef[i]) begin
        bad++; $display("FAIL special_fflags[%0d] got=%h want=%h", i, f, ef[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    op_t v[4];
    v[0] = mk(3'd0, 1'b0, 5'd15, 11'h400, 25'h1000000);
    v[1] = mk(3'd0, 1'b0, 5'd15, 11'h7FF, 25'h1000000);
    v[2] = mk(3'd4, 1'b0, 5'd15, 11'h400, 25'h1000000);
    v[3] = mk(3'd0, 1'b0, 5'd0,  11'h001, 25'h0000001);
    exp_q = {};
    exp_q.push_back({16'h3C00, 5'h01});
    exp_q.push_back({16'h4000, 5'h01});
    exp_q.push_back({16'h3C01, 5'h01});
    exp_q.push_back({16'h0001, 5'h03});
    out_rdy = 1'b1;
    fork
      begin
        bit ok;
        for (int i = 0; i < 4; i++) begin
          put_op(v[i], ok);
          total++; if (!ok) begin bad++; $display("FAIL b2b_accept[%0d] got=0 want=1", i); end
        end
      end
      begin
        logic [15:0] r; logic [4:0] f; int lat; logic [20:0] e;
        for (int i = 0; i < 4; i++) begin
          get_out(r, f, lat);
          e = exp_q.pop_front();
          total++; if (lat < 0 || {r, f} !== e) begin
            bad++; $display("FAIL b2b_out[%0d] got=%h/%h want=%h/%h", i, r, f, e[20:5], e[4:0]);
          end
        end
      end
    join
  endtask

  task automatic test_backpressure();
    bit ok; logic [20:0] e;
    exp_q = {};
    exp_q.push_back({16'h3C00, 5'h01});
    exp_q.push_back({16'h4000, 5'h01});
    exp_q.push_back({16'h0400, 5'h01});
    out_rdy = 1'b0;
    put_op(mk(3'd0, 1'b0, 5'd15, 11'h400, 25'h1000000), ok);
    put_op(mk(3'd0, 1'b0, 5'd15, 11'h7FF, 25'h1000000), ok);
    set_in(mk(3'd3, 1'b0, 5'd0, 11'h3FF, 25'h1800000));
    in_vld = 1'b1;
    total++; if (in_rdy !== 1'b0) begin bad++; $display("FAIL bp_in_rdy_full got=%b want=0", in_rdy); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (out_vld !== 1'b1 || {result, fflags} !== exp_q[0] || in_rdy !== 1'b0) begin
        bad++; $display("FAIL bp_hold[%0d] got=%b/%h/%h rdy=%b want=1/%h/%h rdy=0",
                        i, out_vld, result, fflags, in_rdy, exp_q[0][20:5], exp_q[0][4:0]);
      end
    end
    out_rdy = 1'b1;
    @(negedge clk);
    in_vld = 1'b0;
    e = exp_q.pop_front();
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      total++; if (out_vld !== 1'b1 || {result, fflags} !== e) begin
        bad++; $display("FAIL bp_order[%0d] got=%b/%h/%h want=1/%h/%h", i, out_vld, result, fflags, e[20:5], e[4:0]);
      end
      @(negedge clk);
    end
    total++; if (out_vld !== 1'b0) begin bad++; $display("FAIL bp_drained got=%b want=0", out_vld); end
  endtask

  task automatic test_flush();
    bit ok; logic [15:0] r; logic [4:0] f; int lat; logic stale;
    out_rdy = 1'b0;
    put_op(mk(3'd0, 1'b0, 5'd15, 11'h400, 25'h1000000), ok);
    put_op(mk(3'd0, 1'b0, 5'd15, 11'h7FF, 25'h1000000), ok);
    set_in(mk(3'd3, 1'b0, 5'd0, 11'h3FF, 25'h1800000));
    in_vld  = 1'b1;
    flush   = 1'b1;
    out_rdy = 1'b1;
    @(negedge clk);
    flush  = 1'b0;
    in_vld = 1'b0;
    total++; if (out_vld !== 1'b0 || in_rdy !== 1'b1) begin
      bad++; $display("FAIL flush_clear got=vld%b rdy%b want=vld0 rdy1", out_vld, in_rdy);
    end
    stale = 1'b0;
    repeat (3) begin
      @(negedge clk);
      stale = stale | out_vld;
    end
    total++; if (stale !== 1'b0) begin bad++; $display("FAIL flush_stale got=1 want=0"); end
    put_op(mk(3'd2, 1'b1, 5'd15, 11'h400, 25'h0000001), ok);
    get_out(r, f, lat);
    total++; if (lat !== 1 || r !== 16'hBC01 || f !== 5'h01) begin
      bad++; $display("FAIL flush_next got=%h/%h lat=%0d want=bc01/01 lat=1", r, f, lat);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    out_rdy = 1'b0;
    put_op(mk(3'd0, 1'b0, 5'd15, 11'h400, 25'h1000000), ok);
    put_op(mk(3'd0, 1'b0, 5'd15, 11'h7FF, 25'h1000000), ok);
    cpurst = 1'b1;
    @(negedge clk);
    cpurst  = 1'b0;
    out_rdy = 1'b1;
    total++; if (out_vld !== 1'b0 || in_rdy !== 1'b1 || result !== 16'h0 || fflags !== 5'h0) begin
      bad++; $display("FAIL reset_mid got=vld%b rdy%b %h/%h want=vld0 rdy1 0000/00", out_vld, in_rdy, result, fflags);
    end
    @(negedge clk);
    total++; if (out_vld !== 1'b0) begin bad++; $display("FAIL reset_mid_stale got=%b want=0", out_vld); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_rounding();
    test_overflow();
    test_specials();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
